// File: rtl/spi_ecc_pkg.sv
// spi_ecc_pkg: command codes, sync marker and FSM encoding shared by the SPI front end
package spi_ecc_pkg;
  localparam logic [7:0] CMD_WRITE_OP = 8'h01;
  localparam logic [7:0] CMD_READ_X   = 8'h02;
  localparam logic [7:0] CMD_READ_Y   = 8'h03;
  localparam logic [7:0] CMD_STATUS   = 8'h04;
  localparam logic [7:0] SYNC_MARKER  = 8'hA5;
  typedef enum logic [2:0] {WAIT_CS, IDLE, CMD, WR, RD, IGNORE} state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-stage synchroniser with rise/fall detect on the synced value
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  // shift the async input through the chain and keep a 1-clk delayed copy of the output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/spi_slave_frontend.sv
// spi_slave_frontend: clk-domain SPI mode-0 slave that loads the ECC operand and reads results back
module spi_slave_frontend
  import spi_ecc_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] result_dx,
  input  logic [DATA_W-1:0] result_dy,
  input  logic              result_valid,
  input  logic              core_busy,
  output logic [DATA_W-1:0] operand,
  output logic              operand_valid,
  output logic              frame_abort
);
  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB + 1);
  state_t state, state_n;
  logic cs_q, cs_rise, cs_fall, sck_q, sck_rise, sck_fall, mosi_q;
  logic commit, abort, wr_done, byte_done, wr_last, in_frame;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [2:0] bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte, tx_shift;
  logic [DATA_W-1:0] shadow, snap;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .rst_n(rst_n), .d(spi_clk), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );

  // MOSI only needs the synchroniser, kept at the same depth as SCLK so they stay aligned
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mosi_sync <= '0;
    else mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};

  assign mosi_q    = mosi_sync[SYNC_STAGES-1];
  assign rx_byte   = {rx_shift, mosi_q};
  assign byte_done = sck_rise && bit_cnt == 3'd7;
  assign wr_last   = byte_cnt == BW'(NB - 1);
  assign in_frame  = !cs_q && state inside {CMD, WR, RD, IGNORE};
  assign spi_miso  = tx_shift[7];

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WAIT_CS;
    else state <= state_n;

  // next state; a CS rise overrides any SCLK edge seen in the same clk
  always_comb begin
    state_n = state;
    commit  = 1'b0;
    abort   = 1'b0;
    case (state)
      WAIT_CS: state_n = (cs_q && !sck_q) ? IDLE : WAIT_CS;
      IDLE:    state_n = cs_fall ? CMD : IDLE;
      CMD:     state_n = !byte_done ? CMD :
                         rx_byte == CMD_WRITE_OP ? WR :
                         rx_byte inside {CMD_READ_X, CMD_READ_Y, CMD_STATUS} ? RD : IGNORE;
      WR: begin
        commit  = byte_done && wr_last;
        state_n = commit ? IGNORE : WR;
      end
      default: state_n = state;
    endcase
    if (cs_rise && state != WAIT_CS) begin
      state_n = IDLE;
      commit  = 1'b0;
      abort   = state == WR;
    end
  end

  // frame datapath: bit/byte counting, operand shadow, read snapshot and MISO shifter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      operand       <= '0;
      operand_valid <= 1'b0;
      frame_abort   <= 1'b0;
      wr_done       <= 1'b0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      shadow        <= '0;
      snap          <= '0;
    end else begin
      wr_done       <= commit;
      operand_valid <= wr_done;
      frame_abort   <= abort;
      if (wr_done) operand <= shadow;
      if (state == IDLE && cs_fall) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        tx_shift <= SYNC_MARKER;
      end else if (!in_frame) begin
        tx_shift <= '0;
      end else if (sck_rise) begin
        rx_shift <= rx_byte[6:0];
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7 && state == WR) begin
          shadow   <= {rx_byte, shadow[DATA_W-1:8]};
          byte_cnt <= byte_cnt + 1'b1;
        end
        if (bit_cnt == 3'd7 && state == CMD)
          snap <= rx_byte == CMD_READ_X ? result_dx :
                  rx_byte == CMD_READ_Y ? result_dy : DATA_W'({core_busy, result_valid});
      end else if (sck_fall) begin
        if (state == RD && bit_cnt == 3'd0) begin
          tx_shift <= snap[7:0];
          snap     <= {8'h00, snap[DATA_W-1:8]};
        end else begin
          tx_shift <= (state == CMD || state == RD) ? {tx_shift[6:0], 1'b0} : 8'h00;
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_frontend.sv
// tb_spi_slave_frontend: directed SPI frames against hand-computed operand and MISO bytes
module tb_spi_slave_frontend;
  localparam int DW = 64;
  logic clk = 1'b0, rst_n = 1'b0, spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic spi_miso, result_valid = 1'b0, core_busy = 1'b0, operand_valid, frame_abort;
  logic [DW-1:0] result_dx = '0, result_dy = '0, operand;
  logic [63:0] exp_x;
  logic [7:0] tx [0:15];
  logic [7:0] rx [0:15];
  int total = 0, fails = 0, ov_cnt = 0, fa_cnt = 0, both_cnt = 0, ov0, fa0;

  spi_slave_frontend #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .result_dx(result_dx), .result_dy(result_dy),
    .result_valid(result_valid), .core_busy(core_busy), .operand(operand),
    .operand_valid(operand_valid), .frame_abort(frame_abort)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (operand_valid) ov_cnt <= ov_cnt + 1;
    if (frame_abort) fa_cnt <= fa_cnt + 1;
    if (operand_valid && frame_abort) both_cnt <= both_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      wait_clk(5);
      spi_clk = 1'b1;
      mi[i] = spi_miso;
      wait_clk(5);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_hi();
    wait_clk(6);
    spi_cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic frame(input int n);
    cs_lo();
    for (int i = 0; i < n; i++) xfer(tx[i], rx[i]);
    cs_hi();
  endtask

  initial begin
    wait_clk(3);
    check("rst_miso", 64'(spi_miso), 64'd0);
    check("rst_operand", operand, 64'd0);
    check("rst_opvalid", 64'(operand_valid), 64'd0);
    check("rst_abort", 64'(frame_abort), 64'd0);
    rst_n = 1'b1;
    wait_clk(10);

    tx[0] = 8'h01;
    for (int i = 1; i <= 8; i++) tx[i] = 8'(i * 17);
    frame(9);
    check("wr_marker", 64'(rx[0]), 64'hA5);
    check("wr_miso_data", 64'(rx[1]), 64'h00);
    check("wr_operand", operand, 64'h8877665544332211);
    check("wr_opvalid_cnt", 64'(ov_cnt), 64'd1);
    check("wr_abort_cnt", 64'(fa_cnt), 64'd0);

    result_valid = 1'b1;
    result_dx = 64'h0123456789ABCDEF;
    result_dy = 64'hFEDCBA9876543210;
    exp_x = 64'h0123456789ABCDEF;
    tx[0] = 8'h02;
    for (int i = 1; i <= 8; i++) tx[i] = 8'hFF;
    frame(9);
    check("rdx_marker", 64'(rx[0]), 64'hA5);
    for (int i = 1; i <= 8; i++) check($sformatf("rdx_byte%0d", i), 64'(rx[i]), 64'(exp_x[8*(i-1) +: 8]));

    tx[0] = 8'h03;
    frame(9);
    check("rdy_byte1", 64'(rx[1]), 64'h10);
    check("rdy_byte8", 64'(rx[8]), 64'hFE);

    ov0 = ov_cnt;
    fa0 = fa_cnt;
    tx[0] = 8'h01;
    for (int i = 1; i <= 5; i++) tx[i] = 8'(8'hA0 + i);
    frame(6);
    check("short_abort", 64'(fa_cnt - fa0), 64'd1);
    check("short_opvalid", 64'(ov_cnt - ov0), 64'd0);
    check("short_operand", operand, 64'h8877665544332211);

    core_busy = 1'b1;
    result_valid = 1'b0;
    tx[0] = 8'h04;
    frame(3);
    check("status_byte0", 64'(rx[1]), 64'h02);
    check("status_byte1", 64'(rx[2]), 64'h00);
    core_busy = 1'b0;

    tx[0] = 8'h7E;
    frame(4);
    check("ignore_miso", {40'd0, rx[1], rx[2], rx[3]}, 64'd0);
    check("ignore_operand", operand, 64'h8877665544332211);

    ov0 = ov_cnt;
    fa0 = fa_cnt;
    cs_lo();
    xfer(8'h01, rx[0]);
    xfer(8'h55, rx[1]);
    xfer(8'h66, rx[2]);
    rst_n = 1'b0;
    wait_clk(3);
    check("midrst_operand", operand, 64'd0);
    check("midrst_miso", 64'(spi_miso), 64'd0);
    rst_n = 1'b1;
    wait_clk(4);
    xfer(8'h77, rx[3]);
    xfer(8'h88, rx[4]);
    check("waitcs_miso", {48'd0, rx[3], rx[4]}, 64'd0);
    check("waitcs_events", 64'((ov_cnt - ov0) + (fa_cnt - fa0)), 64'd0);
    check("waitcs_operand", operand, 64'd0);
    cs_hi();
    tx[0] = 8'h01;
    for (int i = 1; i <= 8; i++) tx[i] = 8'(8'hC0 + i - 1);
    frame(9);
    check("postrst_operand", operand, 64'hC7C6C5C4C3C2C1C0);
    check("postrst_opvalid", 64'(ov_cnt - ov0), 64'd1);

    result_valid = 1'b1;
    result_dx = 64'h0123456789ABCDEF;
    cs_lo();
    xfer(8'h02, rx[0]);
    xfer(8'hFF, rx[1]);
    xfer(8'hFF, rx[2]);
    result_dx = 64'hDEADBEEFDEADBEEF;
    for (int i = 3; i <= 8; i++) xfer(8'hFF, rx[i]);
    cs_hi();
    for (int i = 1; i <= 8; i++) check($sformatf("snap_byte%0d", i), 64'(rx[i]), 64'(exp_x[8*(i-1) +: 8]));

    ov0 = ov_cnt;
    fa0 = fa_cnt;
    tx[0] = 8'h01;
    for (int i = 1; i <= 9; i++) tx[i] = 8'(8'h30 + i);
    frame(10);
    check("wr9_operand", operand, 64'h3837363534333231);
    check("wr9_opvalid", 64'(ov_cnt - ov0), 64'd1);
    check("wr9_abort", 64'(fa_cnt - fa0), 64'd0);
    check("never_both", 64'(both_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
    $finish;
  end
endmodule
